jam_cost_loader: RTL
====================

// Module: jam_cost_loader
// PURPOSE
//  Upstream stage of the JAM assignment-search engine. Accepts one 8x8 cost table over a valid/ready
//  stream and serves it to JAM's W/J cost port. Holds JAM in reset while loading and releases it when
//  the table is complete. Captures JAM's MinCost/MatchCount when its Valid rises, presents them on a
//  result handshake, then re-arms for the next table.
// PARAMETERS
//  COST_W       7      cost entry width (matches JAM Cost)
//  MIN_W        10     result MinCost width (matches JAM MinCost)
//  TIMEOUT_CYC  65535  max RUN cycles before abort (full JAM run is ~40386 cycles)
// PORTS
//  CLK          in   1       sole clock; all state updates on posedge
//  RST          in   1       synchronous, active-high reset
//  s_valid      in   1       cost beat valid
//  s_ready      out  1       loader accepts beat (registered; 1 only in LOAD)
//  s_cost       in   COST_W  cost beat; row-major order, beat k = worker k[5:3], job k[2:0]
//  s_last       in   1       marks final beat of a table (must coincide with beat 63)
//  jam_rst      out  1       reset to JAM (registered)
//  W            in   3       JAM worker index
//  J            in   3       JAM job index
//  Cost         out  COST_W  table[W][J], combinational (JAM samples it in the same cycle)
//  jam_valid    in   1       JAM Valid (JAM updates it on negedge; sampled here on posedge)
//  jam_min_cost in   MIN_W   JAM MinCost
//  jam_match    in   4       JAM MatchCount
//  res_valid    out  1       result available
//  res_ready    in   1       consumer accepts result
//  res_min_cost out  MIN_W   captured MinCost
//  res_match    out  4       captured MatchCount
//  err_proto    out  1       sticky: bad s_last framing seen
//  err_timeout  out  1       sticky: RUN exceeded TIMEOUT_CYC
// BEHAVIOUR
//  Reset values: state=LOAD, wr_cnt=0, s_ready=1, jam_rst=1, res_valid=0, res_min_cost=0,
//   res_match=0, err_proto=0, err_timeout=0. RST mid-operation aborts any load, run or report;
//   the table contents are kept but invalid.
//  LOAD: beat accepted on s_valid&&s_ready. Write table[wr_cnt]; wr_cnt++. Gaps in s_valid are allowed.
//   - Beat 63 with s_last: go to RUN. jam_rst=0 and s_ready=0 from the next cycle.
//   - s_last on beat <63, or beat 63 without s_last: set err_proto and set wr_cnt=0.
//     Stay in LOAD. The table is discarded (overwritten by the next load).
//  RUN: jam_rst=0. wd_cnt counts from 0.
//   - jam_valid is ignored in the first RUN cycle.
//   - On jam_valid=1: latch jam_min_cost/jam_match into res_*, set res_valid=1, go to REPORT.
//   - wd_cnt==TIMEOUT_CYC-1 without jam_valid: set err_timeout, jam_rst=1, go to LOAD with wr_cnt=0.
//   - If jam_valid and timeout occur in the same cycle, jam_valid wins.
//  REPORT: res_valid=1 and res_* stay stable until res_ready.
//   - On handshake: res_valid=0, jam_rst=1, wr_cnt=0, go to LOAD. s_ready=1 the following cycle.
//   - res_ready may already be high in the first REPORT cycle (1-cycle report).
//  Table is written only in LOAD, so Cost is stable for the whole RUN.
//  Cost read is a pure mux of table[{W,J}]. Its value outside RUN is don't-care.
//  res_match is passed through at 4 bits; no widening or saturation.
//  err_* are cleared only by RST.
// STRUCTURE
//  Shared package jam_pkg: COST_W, MIN_W, N_ENTRIES=64, state encoding {LOAD,RUN,REPORT}.
//  Sub-module jam_cost_ram: 64 x COST_W, one synchronous write port, one asynchronous read port.
//  Top level holds the FSM, wr_cnt[5:0], wd_cnt[15:0], the result registers and the error flags.
// TESTING (bench uses the real JAM instance downstream)
//  1 Load cost 1 on the diagonal and 50 elsewhere, with random s_valid gaps
//    -> s_ready drops after beat 63; res_min_cost=8, res_match=1.
//  2 Load all costs = 10 -> res_min_cost=80, res_match=0 (40320 mod 16; checks 4-bit pass-through).
//  3 s_last on beat 10 -> err_proto=1, wr_cnt=0, jam_rst stays 1;
//    a following correct 64-beat load completes normally.
//  4 Hold res_ready=0 for 100 cycles in REPORT -> res_valid and res_* stable, s_ready=0;
//    then pulse res_ready -> s_ready=1 next cycle, jam_rst=1.
//  5 Assert RST at RUN cycle 1000 -> next cycle state=LOAD, jam_rst=1, res_valid=0, err_*=0;
//    a reload produces a correct result.
//  6 TIMEOUT_CYC=100 -> err_timeout=1 after RUN cycle 100, jam_rst=1, s_ready=1, no res_valid.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared definitions for the JAM cost loader: table geometry, entry widths
// and the loader state encoding.
package jam_pkg;
  localparam int COST_W    = 7;
  localparam int MIN_W     = 10;
  localparam int N_ENTRIES = 64;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;
endpackage

// File: rtl/jam_cost_ram.sv
// Cost table storage: one synchronous write port for the loader and one
// asynchronous read port so JAM sees table[W][J] in the same cycle.
module jam_cost_ram #(
  parameter int COST_W = 7,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [COST_W-1:0] rdata
);
  logic [COST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/jam_cost_loader.sv
// Loads an 8x8 cost table from a valid/ready stream, holds JAM in reset while
// loading, then captures and reports JAM's result before re-arming.
module jam_cost_loader #(
  parameter int COST_W      = jam_pkg::COST_W,
  parameter int MIN_W       = jam_pkg::MIN_W,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [COST_W-1:0] s_cost,
  input  logic              s_last,
  output logic              jam_rst,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              jam_valid,
  input  logic [MIN_W-1:0]  jam_min_cost,
  input  logic [3:0]        jam_match,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [MIN_W-1:0]  res_min_cost,
  output logic [3:0]        res_match,
  output logic              err_proto,
  output logic              err_timeout
);
  import jam_pkg::*;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [5:0]  wr_cnt;
  logic [15:0] wd_cnt;
  logic        beat;

  // s_ready is only high in LOAD, so a beat implies LOAD and the table
  // cannot change while JAM is running.
  assign beat = s_valid && s_ready;

  jam_cost_ram #(
    .COST_W(COST_W),
    .DEPTH (N_ENTRIES)
  ) u_ram (
    .clk  (CLK),
    .we   (beat),
    .waddr(wr_cnt),
    .wdata(s_cost),
    .raddr({W, J}),
    .rdata(Cost)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= LOAD;
      wr_cnt       <= '0;
      wd_cnt       <= '0;
      s_ready      <= 1'b1;
      jam_rst      <= 1'b1;
      res_valid    <= 1'b0;
      res_min_cost <= '0;
      res_match    <= '0;
      err_proto    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (beat) begin
            if (wr_cnt == 6'd63 && s_last) begin
              state   <= RUN;
              s_ready <= 1'b0;
              jam_rst <= 1'b0;
              wd_cnt  <= '0;
              wr_cnt  <= '0;
            end else if (s_last || wr_cnt == 6'd63) begin
              err_proto <= 1'b1;
              wr_cnt    <= '0;
            end else begin
              wr_cnt <= wr_cnt + 6'd1;
            end
          end
        end
        RUN: begin
          // JAM's Valid is not trusted in the cycle it leaves reset.
          if (jam_valid && wd_cnt != 16'd0) begin
            res_min_cost <= jam_min_cost;
            res_match    <= jam_match;
            res_valid    <= 1'b1;
            state        <= REPORT;
          end else if (wd_cnt == WD_LAST) begin
            err_timeout <= 1'b1;
            jam_rst     <= 1'b1;
            s_ready     <= 1'b1;
            wr_cnt      <= '0;
            state       <= LOAD;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            jam_rst   <= 1'b1;
            s_ready   <= 1'b1;
            wr_cnt    <= '0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
